adder_carry_select_serial: RTL and testbench
============================================

# adder_carry_select_serial

Parametrised, segment-serial carry-select adder with val/rdy handshakes on input and output. It adds two WIDTH-bit operands one SEG-bit segment per cycle. For each segment it computes both carry-in alternatives and selects with the registered carry. It is the multi-cycle, width-generic successor to the fixed 8-bit combinational carry-select adder, for datapaths where area matters more than single-cycle latency.

## Interface
- WIDTH, 32, operand and sum width; must be a positive multiple of SEG
- SEG, 8, segment width in bits processed per cycle; NSEG = WIDTH/SEG
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous and active-high
- in_val  input  1  operands valid
- in_rdy  output  1  block can accept operands
- in0  input  WIDTH  operand A
- in1  input  WIDTH  operand B
- cin  input  1  carry-in to segment 0
- out_val  output  1  sum/cout valid
- out_rdy  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out of the top segment
- sub  input  1  subtract select; present only with ADDER_CS_SUB_EN

## Operation
- FSM has three states: IDLE, CALC, DONE. Segment index register idx is ceil(log2(NSEG)) bits wide, minimum 1.
- IDLE: in_rdy=1, out_val=0. When in_val&&in_rdy: latch in0, in1, cin into the operand regs and carry reg c; clear idx to 0; go to CALC.
- CALC: in_rdy=0, out_val=0. Each cycle, segment idx computes s0 = A_seg + B_seg + 0 and s1 = A_seg + B_seg + 1, each SEG+1 bits wide.
- The selected value is s1 if c is 1, else s0. Its low SEG bits are written into sum[idx*SEG +: SEG], its MSB into c, and idx increments.
- When idx==NSEG-1, the selected carry is also written to cout and the FSM goes to DONE.
- DONE: out_val=1 and in_rdy=0. sum and cout are held stable. When out_rdy=1, go to IDLE.
- Arithmetic: result is modulo 2^WIDTH. cout is bit WIDTH of in0+in1+cin. Operand regs do not change during CALC/DONE.
- sum slices not yet written during CALC are undefined to the consumer. They are valid only while out_val=1.
- in_val in CALC/DONE is ignored and no operands are captured. out_rdy outside DONE is ignored.
- Reset, including mid-CALC or mid-DONE: the FSM goes to IDLE and the in-flight operation is discarded.
- Reset values: in_rdy=1, out_val=0, sum=0, cout=0, idx=0, c=0, operand regs=0.
- NSEG==1 is legal: CALC lasts exactly one cycle.

## Timing
- Acceptance edge E: in_val&&in_rdy is sampled at E.
- CALC occupies the NSEG cycles after E. out_val rises in the cycle after the last CALC edge, i.e. it is first visible NSEG+1 cycles after E.
- Minimum initiation interval: NSEG+2 cycles (accept, NSEG calc, DONE with out_rdy=1, then IDLE).
- in_rdy and out_val are decoded from state registers only. There is no combinational path from in_val or out_rdy to any output.

## Configuration
- ADDER_CS_SUB_EN defined: the sub port exists and is captured with the operands.
  - When sub=1, B is latched as ~in1 and c as 1, so result = in0 - in1 and cout = NOT borrow. cin is ignored.
  - When sub=0, behaviour is identical to the undefined case.
- ADDER_CS_SUB_EN undefined: there is no sub port and no inversion logic. The block is addition only.

## Structure
- The shared package/include holds the FSM state encodings (STATE_IDLE, STATE_CALC, STATE_DONE, 2 bits) and the NSEG/index-width helper constant functions.
- One sub-module: adder_cs_segment, parametrised by SEG. It is a combinational dual ripple adder plus a 2:1 select with inputs a, b, csel and outputs s, co. It is instantiated once and reused each CALC cycle through idx-based operand slicing.

## Test plan
- WIDTH=32, SEG=8: 0x000000FF + 0x00000001, cin=0 -> out_val rises 5 cycles after acceptance; sum=0x00000100, cout=0.
- 0xFFFFFFFF + 0x00000000, cin=1 -> carry propagates through all 4 segments; sum=0x00000000, cout=1.
- Backpressure: out_rdy=0 for 3 cycles in DONE -> sum/cout held, in_rdy=0, a new in_val is ignored; out_rdy=1 -> IDLE next cycle, in_rdy=1.
- Assert rst during the 2nd CALC cycle -> next cycle in_rdy=1, out_val=0, sum=0, cout=0. A fresh 3+4 then returns sum=7.
- WIDTH=8, SEG=4 (NSEG=2): 0x7F + 0x01 -> sum=0x80, cout=0 after 3 cycles. Also 0xF0 + 0x10 -> sum=0x00, cout=1.
- ADDER_CS_SUB_EN, WIDTH=32: sub=1, 5 - 7 -> sum=0xFFFFFFFE, cout=0. Also 7 - 5 -> sum=2, cout=1.

Source files
------------

// File: rtl/adder_carry_select_serial_pkg.sv
// adder_carry_select_serial_pkg: FSM state encodings and segment-count/index-width helpers
package adder_carry_select_serial_pkg;
  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_CALC = 2'd1,
    STATE_DONE = 2'd2
  } state_t;
  function automatic int nseg(input int w, input int s);
    return w / s;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adder_carry_select_serial_segment.sv
// adder_cs_segment: one SEG-bit carry-select slice (ports a, b, csel -> s, co)
module adder_cs_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           csel,
  output logic [SEG-1:0] s,
  output logic           co
);
  logic [SEG:0] s0, s1;
  assign s0 = {1'b0, a} + {1'b0, b};
  assign s1 = {1'b0, a} + {1'b0, b} + (SEG+1)'(1);
  assign {co, s} = csel ? s1 : s0;
endmodule

// File: rtl/adder_carry_select_serial.sv
// adder_carry_select_serial: segment-serial carry-select adder with val/rdy handshakes (ports clk, rst, in_val/in_rdy/in0/in1/cin, out_val/out_rdy/sum/cout, sub with ADDER_CS_SUB_EN)
module adder_carry_select_serial
  import adder_carry_select_serial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_CS_SUB_EN
  ,
  input  logic             sub
`endif
);
  localparam int NSEG = nseg(WIDTH, SEG);
  localparam int IW   = idx_w(NSEG);
  localparam logic [IW-1:0] LAST = IW'(NSEG - 1);
  state_t                     state;
  logic [NSEG-1:0][SEG-1:0]   a, b, s;
  logic                       c;
  logic [IW-1:0]              idx;
  logic [SEG-1:0]             seg_s;
  logic                       seg_co;
  logic [WIDTH-1:0]           b_in;
  logic                       c_in;
`ifdef ADDER_CS_SUB_EN
  assign b_in = sub ? ~in1 : in1;
  assign c_in = sub | cin;
`else
  assign b_in = in1;
  assign c_in = cin;
`endif
  adder_cs_segment #(.SEG(SEG)) u_seg (
    .a   (a[idx]),
    .b   (b[idx]),
    .csel(c),
    .s   (seg_s),
    .co  (seg_co)
  );
  assign sum     = s;
  assign in_rdy  = state == STATE_IDLE;
  assign out_val = state == STATE_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STATE_IDLE;
      a     <= '0;
      b     <= '0;
      s     <= '0;
      c     <= 1'b0;
      cout  <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        STATE_IDLE: if (in_val) begin
          a     <= in0;
          b     <= b_in;
          c     <= c_in;
          idx   <= '0;
          state <= STATE_CALC;
        end
        STATE_CALC: begin
          s[idx] <= seg_s;
          c      <= seg_co;
          idx    <= idx + IW'(1);
          if (idx == LAST) begin
            cout  <= seg_co;
            state <= STATE_DONE;
          end
        end
        STATE_DONE: if (out_rdy) state <= STATE_IDLE;
        default: state <= STATE_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_carry_select_serial.sv
// tb_adder_carry_select_serial: randomized and directed checks of the serial carry-select adder against an arithmetic model
module tb_adder_carry_select_serial;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_val = 1'b0, out_rdy = 1'b0, cin = 1'b0;
  logic [31:0] in0 = '0, in1 = '0;
  logic        in_rdy, out_val, cout;
  logic [31:0] sum;
  logic        in_val8 = 1'b0, out_rdy8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  in08 = '0, in18 = '0;
  logic        in_rdy8, out_val8, cout8;
  logic [7:0]  sum8;
  logic        sub = 1'b0;
  int          total = 0, passed = 0;
  always #5 clk = ~clk;
  adder_carry_select_serial #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in0(in0), .in1(in1), .cin(cin),
    .out_val(out_val), .out_rdy(out_rdy), .sum(sum), .cout(cout)
`ifdef ADDER_CS_SUB_EN
    , .sub(sub)
`endif
  );
  adder_carry_select_serial #(.WIDTH(8), .SEG(4)) dut8 (
    .clk(clk), .rst(rst), .in_val(in_val8), .in_rdy(in_rdy8), .in0(in08), .in1(in18), .cin(cin8),
    .out_val(out_val8), .out_rdy(out_rdy8), .sum(sum8), .cout(cout8)
`ifdef ADDER_CS_SUB_EN
    , .sub(1'b0)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                       output logic [31:0] s, output logic co, output int lat);
    in0 = a; in1 = b; cin = ci; sub = sb; in_val = 1'b1; out_rdy = 1'b0;
    tick();
    in_val = 1'b0;
    lat = 1;
    while (!out_val && lat < 50) begin
      tick();
      lat++;
    end
    s = sum; co = cout;
  endtask
  task automatic release32();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) tick();
    rst = 1'b0;
    total++; if ({in_rdy, out_val, cout, sum} !== {1'b1, 1'b0, 1'b0, 32'd0}) $display("FAIL reset32 got rdy=%b val=%b cout=%b sum=%h", in_rdy, out_val, cout, sum); else passed++;
    total++; if ({in_rdy8, out_val8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 8'd0}) $display("FAIL reset8 got rdy=%b val=%b cout=%b sum=%h", in_rdy8, out_val8, cout8, sum8); else passed++;
  endtask
  task automatic test_directed();
    logic [31:0] s; logic co; int lat;
    run32(32'h000000FF, 32'h00000001, 1'b0, 1'b0, s, co, lat);
    total++; if (lat !== 5) $display("FAIL latency got %0d want 5", lat); else passed++;
    total++; if ({co, s} !== {1'b0, 32'h00000100}) $display("FAIL ff_plus_1 got %b_%h want 0_00000100", co, s); else passed++;
    total++; if (in_rdy !== 1'b0) $display("FAIL rdy_in_done got %b want 0", in_rdy); else passed++;
    release32();
    total++; if ({in_rdy, out_val} !== 2'b10) $display("FAIL after_release got rdy=%b val=%b want 1 0", in_rdy, out_val); else passed++;
    run32(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, s, co, lat);
    total++; if ({co, s} !== {1'b1, 32'h0}) $display("FAIL full_carry got %b_%h want 1_00000000", co, s); else passed++;
    release32();
  endtask
  task automatic test_random();
    logic [31:0] a, b, s; logic ci, co; int lat; logic [32:0] exp;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
      if (i == 0) a = 32'hFFFFFFFF;
      exp = 33'(a) + 33'(b) + 33'(ci);
      run32(a, b, ci, 1'b0, s, co, lat);
      total++; if ({co, s} !== exp || lat !== 5) $display("FAIL rand%0d %h+%h+%b got %b_%h lat %0d want %b_%h lat 5", i, a, b, ci, co, s, lat, exp[32], exp[31:0], lat); else passed++;
      repeat ($urandom_range(0, 2)) tick();
      release32();
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] s; logic co; int lat;
    run32(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, s, co, lat);
    for (int i = 0; i < 3; i++) begin
      in0 = 32'h11111111; in1 = 32'h22222222; in_val = 1'b1;
      tick();
      total++; if ({cout, sum, in_rdy, out_val} !== {1'b0, 32'hACF13568, 1'b0, 1'b1}) $display("FAIL hold%0d got %b_%h rdy=%b val=%b want 0_acf13568 0 1", i, cout, sum, in_rdy, out_val); else passed++;
    end
    in_val = 1'b0;
    release32();
    total++; if ({in_rdy, out_val} !== 2'b10) $display("FAIL bp_release got rdy=%b val=%b want 1 0", in_rdy, out_val); else passed++;
    run32(32'd1, 32'd1, 1'b0, 1'b0, s, co, lat);
    total++; if ({co, s} !== {1'b0, 32'd2}) $display("FAIL after_bp got %b_%h want 0_00000002", co, s); else passed++;
    release32();
  endtask
  task automatic test_reset_mid_calc();
    logic [31:0] s; logic co; int lat;
    in0 = 32'hFFFFFFFF; in1 = 32'hFFFFFFFF; cin = 1'b1; in_val = 1'b1;
    tick();
    in_val = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({in_rdy, out_val, cout, sum} !== {1'b1, 1'b0, 1'b0, 32'd0}) $display("FAIL mid_reset got rdy=%b val=%b cout=%b sum=%h want 1 0 0 0", in_rdy, out_val, cout, sum); else passed++;
    run32(32'd3, 32'd4, 1'b0, 1'b0, s, co, lat);
    total++; if ({co, s} !== {1'b0, 32'd7}) $display("FAIL after_reset got %b_%h want 0_00000007", co, s); else passed++;
    release32();
  endtask
  task automatic test_nseg2();
    logic [7:0] a [4] = '{8'h7F, 8'hF0, 8'hA5, 8'h00};
    logic [7:0] b [4] = '{8'h01, 8'h10, 8'h5B, 8'h00};
    logic [8:0] exp;
    int lat;
    for (int i = 0; i < 4; i++) begin
      in08 = a[i]; in18 = b[i]; cin8 = (i == 3); in_val8 = 1'b1;
      exp = 9'(a[i]) + 9'(b[i]) + 9'(cin8);
      tick();
      in_val8 = 1'b0;
      lat = 1;
      while (!out_val8 && lat < 50) begin
        tick();
        lat++;
      end
      total++; if ({cout8, sum8} !== exp || lat !== 3) $display("FAIL w8_%0d got %b_%h lat %0d want %b_%h lat 3", i, cout8, sum8, lat, exp[8], exp[7:0]); else passed++;
      out_rdy8 = 1'b1;
      tick();
      out_rdy8 = 1'b0;
    end
  endtask
`ifdef ADDER_CS_SUB_EN
  task automatic test_sub();
    logic [31:0] s; logic co; int lat;
    run32(32'd5, 32'd7, 1'b0, 1'b1, s, co, lat);
    total++; if ({co, s} !== {1'b0, 32'hFFFFFFFE}) $display("FAIL sub_5_7 got %b_%h want 0_fffffffe", co, s); else passed++;
    release32();
    run32(32'd7, 32'd5, 1'b1, 1'b1, s, co, lat);
    total++; if ({co, s} !== {1'b1, 32'd2}) $display("FAIL sub_7_5 got %b_%h want 1_00000002", co, s); else passed++;
    release32();
    sub = 1'b0;
  endtask
`endif
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    test_nseg2();
`ifdef ADDER_CS_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
